// File: rtl/a53_burst_cipher.sv
// a53_burst_cipher: XORs a serial burst of BURST_LEN bits with keystream
// taken MSB first from one 128-bit full_kasumi output block.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             request a new burst (honoured only in IDLE)
//   ks_req            asking upstream for a keystream block
//   ks_valid, ks_data keystream block handshake from full_kasumi
//   din, din_valid    serial input bit and its valid
//   din_ready         input bit is accepted this cycle
//   dout, dout_valid  registered output bit (din ^ keystream) and its valid
//   dout_ready        consumer accepts dout
//   busy              block is in any state other than IDLE
//   done              one-cycle pulse after the final output bit is accepted
module a53_burst_cipher #(
  parameter int unsigned BURST_LEN = 114
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ks_req,
  input  logic         ks_valid,
  input  logic [127:0] ks_data,
  input  logic         din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         busy,
  output logic         done
);

  localparam int unsigned KS_W  = 128;
  localparam int unsigned CNT_W = 7;
  // Compared before the increment so BURST_LEN=128 works with a 7-bit counter.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_KS = 2'd1,
    RUN     = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [KS_W-1:0]  ks_sh;
  logic             xfer;
  logic             accept;
  logic             last_xfer;

  assign xfer      = din_valid & din_ready;
  assign accept    = dout_valid & dout_ready;
  assign last_xfer = xfer & (cnt == LAST_CNT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = WAIT_KS;
      WAIT_KS: if (ks_valid)  state_nxt = RUN;
      RUN:     if (last_xfer) state_nxt = DRAIN;
      DRAIN:   if (accept)    state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs; din_ready follows dout_ready so a full pipe keeps 1 bit/cycle
  always_comb begin
    ks_req    = 1'b0;
    din_ready = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE:    busy      = 1'b0;
      WAIT_KS: ks_req    = 1'b1;
      RUN:     din_ready = ~dout_valid | dout_ready;
      default: ;
    endcase
  end

  // Datapath: counter, keystream shifter, output register, done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      ks_sh      <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= (state == DRAIN) & accept;
      if ((state == IDLE) && start) cnt <= '0;
      if ((state == WAIT_KS) && ks_valid) ks_sh <= ks_data;
      if (xfer) begin
        dout       <= din ^ ks_sh[KS_W-1];
        dout_valid <= 1'b1;
        ks_sh      <= {ks_sh[KS_W-2:0], 1'b0};
        cnt        <= cnt + CNT_W'(1);
      end else if (accept) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/a53_burst_cipher.md
A53_BURST_CIPHER -- requirements
Module: a53_burst_cipher

Interface
REQ-001 SHALL have parameter BURST_LEN, default 114, giving the number of keystream bits applied per burst; legal range 1..128.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: requests a new burst.
REQ-005 SHALL have port ks_req, output, 1 bit: requests a keystream block from the upstream full_kasumi stage.
REQ-006 SHALL have port ks_valid, input, 1 bit: keystream block present on ks_data.
REQ-007 SHALL have port ks_data, input, 128 bits: the kasumi_out word from full_kasumi.
REQ-008 SHALL have port din, input, 1 bit: plaintext or ciphertext burst bit.
REQ-009 SHALL have port din_valid, input, 1 bit: din is valid.
REQ-010 SHALL have port din_ready, output, 1 bit: block accepts din this cycle.
REQ-011 SHALL have port dout, output, 1 bit: din XOR keystream bit.
REQ-012 SHALL have port dout_valid, output, 1 bit: dout is valid.
REQ-013 SHALL have port dout_ready, input, 1 bit: consumer accepts dout.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse at burst completion.

Function
REQ-016 SHALL implement four states: IDLE, WAIT_KS, RUN, DRAIN.
REQ-017 IDLE: start=1 SHALL move the block to WAIT_KS and clear the 7-bit bit counter cnt to 0.
REQ-018 WAIT_KS: ks_req SHALL be 1; ks_valid=1 SHALL load ks_data into the 128-bit shift register ks_sh and move the block to RUN.
REQ-019 ks_valid outside WAIT_KS, including the cycle start is sampled in IDLE, SHALL be ignored.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 RUN: din_ready SHALL equal (!dout_valid | dout_ready); it SHALL be 0 in every other state.
REQ-022 A din transfer (din_valid & din_ready) SHALL register dout <= din ^ ks_sh[127], set dout_valid, shift ks_sh left by 1, and increment cnt.
REQ-023 Keystream SHALL be consumed MSB first: burst bit k uses ks_data[127-k].
REQ-024 The din-transfer-to-dout_valid latency SHALL be exactly 1 cycle.
REQ-025 dout_valid SHALL clear on (dout_valid & dout_ready) in any cycle without a new transfer; a simultaneous accept and new transfer SHALL keep dout_valid at 1 with the new bit (full throughput, 1 bit/cycle).
REQ-026 The transfer that moves cnt to BURST_LEN (BURST_LEN-1 -> BURST_LEN) SHALL move the block to DRAIN; no further din is accepted.
REQ-027 DRAIN: once the final dout is accepted, the block SHALL pulse done for one cycle and return to IDLE in that same cycle.
REQ-028 Unused ks_sh bits (128-BURST_LEN) SHALL be discarded; cnt SHALL never exceed BURST_LEN.
REQ-029 dout, dout_valid, and the held ks_sh SHALL remain stable while dout_valid=1 and dout_ready=0.
REQ-030 Stalls on din_valid or dout_ready of any length SHALL not alter the keystream sequence.

Reset
REQ-031 rst=1 SHALL force state=IDLE, cnt=0, ks_sh=0, dout=0, dout_valid=0, ks_req=0, din_ready=0, busy=0, done=0 on the next edge.
REQ-032 rst SHALL take priority over all other inputs; a burst interrupted mid-RUN or mid-DRAIN SHALL be abandoned with no done pulse.

Verification
REQ-033 BURST_LEN=4; ks_data=128'hA000...0; din=0,0,0,0 with dout_ready=1 -> dout=1,0,1,0 on consecutive cycles, each 1 cycle after its input; done pulses 1 cycle after the last dout is accepted.
REQ-034 BURST_LEN=114; ks_data all ones; 114 consecutive din=0 -> 114 dout=1; the 115th din is refused (din_ready=0); busy falls with done.
REQ-035 dout_ready held 0 for 5 cycles after the first dout -> dout_valid and dout hold, din_ready=0; after release the sequence continues unchanged.
REQ-036 start and ks_valid asserted in the same IDLE cycle -> ks_valid is ignored, the block stays in WAIT_KS with ks_req=1 until the next ks_valid.
REQ-037 rst asserted after 50 bits of a 114-bit burst -> all outputs are at reset values the next cycle, with no done; a new start begins at ks bit 127.
REQ-038 start asserted during RUN -> no effect on cnt, ks_sh, or the output stream.
